// File: rtl/des_pkg.sv
// Shared types and constants for the byte serializer: FSM state encoding,
// block/byte widths and destination select values.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BLOCK_W = 64;
  localparam int BYTE_W  = 8;

  localparam logic DIR_I2C  = 1'b0;
  localparam logic DIR_SRAM = 1'b1;

endpackage

// File: rtl/output_byte.sv
// Serializes a 64-bit block MSB byte first to either the I2C or SRAM side,
// one byte per consumer ack. Optional byte_parity port via OUTPUT_BYTE_PARITY_EN.
module output_byte
  import des_pkg::*;
#(
  parameter int NUM_BYTES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dir_sel,
  input  logic [BLOCK_W-1:0] input_data,
  input  logic               load,
  input  logic               byte_ack,
  output logic [BYTE_W-1:0]  to_i2c,
  output logic [BYTE_W-1:0]  to_sram,
  output logic               i2c_valid,
  output logic               sram_valid,
  output logic               busy,
  output logic               done
`ifdef OUTPUT_BYTE_PARITY_EN
  ,
  output logic               byte_parity
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [BLOCK_W-1:0] shift_q;
  logic [2:0]         cnt_q;
  logic               dir_q;
  logic               accept;
  logic               advance;
  logic [BYTE_W-1:0]  cur_byte;
  logic               sending;

  // A new block is only taken from IDLE or DONE; load while sending is dropped.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (byte_ack) begin
          advance = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        accept  = load;
        state_d = load ? SEND : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= 3'd0;
      dir_q   <= DIR_I2C;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shift_q <= input_data;
        dir_q   <= dir_sel;
        cnt_q   <= 3'd0;
      end else if (advance) begin
        shift_q <= {shift_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        cnt_q   <= cnt_q + 3'd1;
      end
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    cur_byte   = shift_q[BLOCK_W-1 -: BYTE_W];
    sending    = (state_q == SEND);
    i2c_valid  = sending && (dir_q == DIR_I2C);
    sram_valid = sending && (dir_q == DIR_SRAM);
    to_i2c     = i2c_valid  ? cur_byte : '0;
    to_sram    = sram_valid ? cur_byte : '0;
    busy       = sending;
    done       = (state_q == DONE);
  end

`ifdef OUTPUT_BYTE_PARITY_EN
  // Odd parity: the bit makes the total count of ones odd.
  always_comb begin
    byte_parity = sending ? ~(^cur_byte) : 1'b0;
  end
`endif

endmodule

// File: tb/tb_output_byte.sv
// Directed self-checking bench for output_byte; parity checks are enabled
// when OUTPUT_BYTE_PARITY_EN is defined.
module tb_output_byte;

  logic        clk;
  logic        rst;
  logic        dir_sel;
  logic [63:0] input_data;
  logic        load;
  logic        byte_ack;
  logic [7:0]  to_i2c;
  logic [7:0]  to_sram;
  logic        i2c_valid;
  logic        sram_valid;
  logic        busy;
  logic        done;
`ifdef OUTPUT_BYTE_PARITY_EN
  logic        byte_parity;
`endif

  int total;
  int bad;

  output_byte #(.NUM_BYTES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dir_sel    (dir_sel),
    .input_data (input_data),
    .load       (load),
    .byte_ack   (byte_ack),
    .to_i2c     (to_i2c),
    .to_sram    (to_sram),
    .i2c_valid  (i2c_valid),
    .sram_valid (sram_valid),
    .busy       (busy),
    .done       (done)
`ifdef OUTPUT_BYTE_PARITY_EN
    ,
    .byte_parity(byte_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge take them, then settle 1 time unit.
  task automatic applyStimulus(input logic ld, input logic [63:0] d,
                               input logic ds, input logic ack);
    load       = ld;
    input_data = d;
    dir_sel    = ds;
    byte_ack   = ack;
    @(posedge clk);
    #1;
    load     = 1'b0;
    byte_ack = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [7:0] exp_a [8];
  logic [7:0] exp_b [8];
  logic [7:0] exp_c [8];
  logic [7:0] exp_d [8];
  logic [7:0] exp_e [8];
  logic [7:0] exp_f [8];

  initial begin
    total = 0;
    bad   = 0;
    exp_a = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hab, 8'hcd, 8'hef};
    exp_b = '{8'h12, 8'h34, 8'h78, 8'h90, 8'hab, 8'hcd, 8'h56, 8'hef};
    exp_c = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_d = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7, 8'ha8};
    exp_e = '{8'hb1, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6, 8'hb7, 8'hb8};
    exp_f = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'hf0};

    rst        = 1'b1;
    dir_sel    = 1'b0;
    input_data = '0;
    load       = 1'b0;
    byte_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_i2c_valid", i2c_valid, 0);
    checkOutput("rst_sram_valid", sram_valid, 0);
    checkOutput("rst_to_i2c", to_i2c, 0);
    checkOutput("rst_to_sram", to_sram, 0);
    rst = 1'b0;

    // Block A: I2C, ack every cycle, load on first edge after reset release
    applyStimulus(1'b1, 64'h1234567890abcdef, 1'b0, 1'b0);
    checkOutput("a_busy", busy, 1);
    checkOutput("a_sram_valid", sram_valid, 0);
`ifdef OUTPUT_BYTE_PARITY_EN
    checkOutput("a_parity_12", byte_parity, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("a_to_i2c_%0d", i), to_i2c, exp_a[i]);
      checkOutput($sformatf("a_i2c_valid_%0d", i), i2c_valid, 1);
      checkOutput($sformatf("a_to_sram_%0d", i), to_sram, 0);
      checkOutput($sformatf("a_done_%0d", i), done, 0);
`ifdef OUTPUT_BYTE_PARITY_EN
      checkOutput($sformatf("a_parity_%0d", i), byte_parity, ~(^exp_a[i]));
`endif
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    end
    checkOutput("a_done_pulse", done, 1);
    checkOutput("a_done_busy", busy, 0);
    checkOutput("a_done_i2c_valid", i2c_valid, 0);
    checkOutput("a_done_to_i2c", to_i2c, 0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("a_after_done", done, 0);
    checkOutput("a_after_busy", busy, 0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("idle_ack_ignored", busy, 0);

    // Block B: SRAM, ack every other cycle, inputs wiggled while held
    applyStimulus(1'b1, 64'h12347890abcd56ef, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("b_to_sram_%0d", i), to_sram, exp_b[i]);
      checkOutput($sformatf("b_sram_valid_%0d", i), sram_valid, 1);
      checkOutput($sformatf("b_i2c_valid_%0d", i), i2c_valid, 0);
      checkOutput($sformatf("b_to_i2c_%0d", i), to_i2c, 0);
      applyStimulus(1'b0, 64'hdeadbeefcafef00d, 1'b0, 1'b0);
      checkOutput($sformatf("b_hold_%0d", i), to_sram, exp_b[i]);
      checkOutput($sformatf("b_hold_valid_%0d", i), sram_valid, 1);
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    end
    checkOutput("b_done_pulse", done, 1);
    checkOutput("b_done_sram_valid", sram_valid, 0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);

    // Block C: load during SEND after 3 acks must be ignored
    applyStimulus(1'b1, 64'h0102030405060708, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("c_to_i2c_%0d", i), to_i2c, exp_c[i]);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 64'hffffffffffffffff, 1'b1, 1'b0);
    checkOutput("c_reload_to_i2c", to_i2c, 8'h04);
    checkOutput("c_reload_i2c_valid", i2c_valid, 1);
    checkOutput("c_reload_sram_valid", sram_valid, 0);
    for (int i = 3; i < 8; i++) begin
      checkOutput($sformatf("c_to_i2c_%0d", i), to_i2c, exp_c[i]);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    end
    checkOutput("c_done_pulse", done, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);

    // Block D: reset mid-block after 4 acks
    applyStimulus(1'b1, 64'ha1a2a3a4a5a6a7a8, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("d_to_sram_%0d", i), to_sram, exp_d[i]);
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    end
    checkOutput("d_pre_rst", to_sram, 8'ha5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("d_rst_to_sram", to_sram, 0);
    checkOutput("d_rst_sram_valid", sram_valid, 0);
    checkOutput("d_rst_busy", busy, 0);
    checkOutput("d_rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("d_rst_no_done", done, 0);

    // Block E: restart from byte 0 after reset, then load in DONE cycle
    applyStimulus(1'b1, 64'hb1b2b3b4b5b6b7b8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("e_to_i2c_%0d", i), to_i2c, exp_e[i]);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    end
    checkOutput("e_done_pulse", done, 1);

    // Block F: accepted straight out of DONE
    applyStimulus(1'b1, 64'h123456789abcdef0, 1'b1, 1'b0);
    checkOutput("f_busy", busy, 1);
    checkOutput("f_done_cleared", done, 0);
    checkOutput("f_i2c_valid", i2c_valid, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("f_to_sram_%0d", i), to_sram, exp_f[i]);
      checkOutput($sformatf("f_to_i2c_%0d", i), to_i2c, 0);
`ifdef OUTPUT_BYTE_PARITY_EN
      checkOutput($sformatf("f_parity_%0d", i), byte_parity, ~(^exp_f[i]));
`endif
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    end
    checkOutput("f_done_pulse", done, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    checkOutput("f_idle", done, 0);
`ifdef OUTPUT_BYTE_PARITY_EN
    checkOutput("idle_parity", byte_parity, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_byte.md
OUTPUT_BYTE -- requirements
Module: output_byte

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 8, number of bytes serialized per block.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port dir_sel, input, 1: 0 = I2C destination, 1 = SRAM destination; sampled only at load.
REQ-005 SHALL have port input_data, input, 64, block to serialize, MSB byte first.
REQ-006 SHALL have port load, input, 1, single-cycle request to accept input_data.
REQ-007 SHALL have port byte_ack, input, 1, single-cycle pulse from the consumer marking the current byte taken.
REQ-008 SHALL have port to_i2c, output, 8, current byte when the latched dir = 0, else 8'h00.
REQ-009 SHALL have port to_sram, output, 8, current byte when the latched dir = 1, else 8'h00.
REQ-010 SHALL have port i2c_valid and port sram_valid, output, 1 each, high while a byte is presented to that destination.
REQ-011 SHALL have port busy, output, 1, high while in SEND.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the final byte is acked.

Function
REQ-013 SHALL implement FSM states IDLE, SEND and DONE.
REQ-014 IDLE or DONE with load=1 SHALL capture input_data into a 64-bit shift register, latch dir_sel, clear the 3-bit byte counter and enter SEND.
REQ-015 DONE with load=0 SHALL return to IDLE after one cycle.
REQ-016 In SEND, the current byte SHALL be shift_reg[63:56], driven combinationally to the selected destination, with its valid high.
REQ-017 In SEND, byte_ack=1 SHALL shift the register left by 8 (zero fill) and increment the counter.
REQ-018 byte_ack arriving with counter = NUM_BYTES-1 SHALL enter DONE on the next edge, with valid deasserting in the same edge.
REQ-019 load during SEND SHALL be ignored; input_data and dir_sel changes during SEND SHALL have no effect.
REQ-020 byte_ack in IDLE or DONE SHALL be ignored.
REQ-021 First byte valid SHALL be presented 1 cycle after the accepted load.
REQ-022 Minimum block time SHALL be NUM_BYTES cycles of SEND plus 1 cycle of DONE; back-to-back loads are accepted in DONE.
REQ-023 to_i2c and to_sram SHALL never both be nonzero, and i2c_valid and sram_valid SHALL never both be high.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, shift register 0, counter 0 and latched dir 0, and drive all outputs to 0, including mid-block; a partial block is discarded.
REQ-025 The first load SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 With OUTPUT_BYTE_PARITY_EN defined, the block SHALL add output byte_parity (1 bit), equal to the odd parity of the current byte while either valid is high, and 0 otherwise.
REQ-027 Without OUTPUT_BYTE_PARITY_EN, the byte_parity port and its logic SHALL not exist.

Structure
REQ-028 The shared package (des_pkg) SHALL hold the FSM state enum (IDLE, SEND, DONE), the BLOCK_W=64 and BYTE_W=8 constants, and the DIR_I2C=0 / DIR_SRAM=1 constants.
REQ-029 The block SHALL be a single module with no sub-modules; the counter and shift register are inline.

Verification
REQ-030 Load 64'h1234567890abcdef with dir_sel=0 and ack each cycle -> to_i2c sequence 12,34,56,78,90,ab,cd,ef; to_sram stays 00; done pulses once, 9 cycles after load.
REQ-031 Load 64'h12347890abcd56ef with dir_sel=1 and ack every other cycle -> to_sram 12,34,78,90,ab,cd,56,ef with each byte held until acked; sram_valid never drops mid-block.
REQ-032 Load asserted with 64'hffffffffffffffff during SEND after 3 acks -> remaining bytes still come from the original block; the second load is not accepted.
REQ-033 rst pulsed after the 4th ack -> outputs 0 immediately, FSM in IDLE, no done pulse; a new load then restarts from byte 0.
REQ-034 Load asserted in the DONE cycle -> accepted; the next block's first byte appears on the following cycle.
REQ-035 With OUTPUT_BYTE_PARITY_EN, byte 8'h12 -> byte_parity=1, and byte 8'h34 -> byte_parity=0.
